demux1x4_buf: RTL and testbench

- 1-to-4 routing demultiplexer with handshake; the counterpart of the 16-bit 4:1 select mux in the datapath.
- Steers one input word to one of four destinations chosen by a 2-bit select.
- Each destination has its own small FIFO, so one stalled consumer does not block traffic bound for the other three.
- Sits between a single producer (e.g. writeback/forwarding source) and four independent consumers.

---
 rtl/demux1x4_buf_pkg.sv | 16 +
 rtl/demux_chan_fifo.sv | 94 +++++++++
 rtl/demux1x4_buf.sv | 64 ++++++
 tb/tb_demux1x4_buf.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/demux1x4_buf_pkg.sv
// Shared constants and types for the 1-to-4 buffered routing demultiplexer.
// Imported by the top and by the per-channel FIFO.
package demux1x4_buf_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NUM_OUT   = 4;
  localparam int SEL_W     = 2;

  // Occupancy class of one channel. It is derived from the count and never stored.
  typedef enum logic [1:0] {
    CH_EMPTY   = 2'd0,
    CH_PARTIAL = 2'd1,
    CH_FULL    = 2'd2
  } chan_state_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel DEPTH-entry synchronous FIFO. The head word is read
// combinationally from registered storage, so a push is visible one cycle later.
module demux_chan_fifo
  import demux1x4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  chan_state_e      state;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    state = CH_PARTIAL;
    if (count_reg == '0) begin
      state = CH_EMPTY;
    end else if (count_reg == DEPTH_C) begin
      state = CH_FULL;
    end
  end

  assign full    = (state == CH_FULL);
  assign valid   = (state != CH_EMPTY);
  assign dout    = mem_reg[rd_ptr_reg];

  // A full channel refuses the push even if a pop happens in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Flush only rewinds the pointers. Reset also zeroes the stored words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

endmodule

// File: rtl/demux1x4_buf.sv
// 1-to-4 routing demultiplexer. Each destination has its own FIFO, so a stalled
// consumer only backpressures producer words that are addressed to it.
module demux1x4_buf
  import demux1x4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data
);

  logic [NUM_OUT-1:0] full_vec;
  logic [NUM_OUT-1:0] push_vec;
  logic               sel_full;

  // An unknown select falls to the default arm, so in_ready is never X.
  // This gating does not use in_valid.
  always_comb begin
    sel_full = 1'b0;
    case (in_sel)
      2'd0:    sel_full = full_vec[0];
      2'd1:    sel_full = full_vec[1];
      2'd2:    sel_full = full_vec[2];
      2'd3:    sel_full = full_vec[3];
      default: sel_full = 1'b0;
    endcase
  end

  assign in_ready = !flush && !sel_full;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_chan
      assign push_vec[gi] = in_valid && in_ready && (in_sel == SEL_W'(gi));

      demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_vec[gi]),
        .din   (in_data),
        .pop   (out_ready[gi]),
        .dout  (out_data[gi*WIDTH +: WIDTH]),
        .valid (out_valid[gi]),
        .full  (full_vec[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux1x4_buf.sv
// Self-checking bench for demux1x4_buf. It uses a directed vector table, hand-written
// corner sequences and a random soak, all checked against a four-queue scoreboard.
module tb_demux1x4_buf;

  localparam int W = 16;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = 2'd0;
  logic [W-1:0]  in_data = '0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'b0000;
  logic [4*W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb [4][$];

  typedef struct {
    logic         v;
    logic [1:0]   s;
    logic [W-1:0] d;
    logic [3:0]   r;
    logic         f;
    logic         exp_ready;
    logic [3:0]   exp_valid;
  } vec_t;

  vec_t tbl [14];

  demux1x4_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                              input logic [3:0] r, input logic er, input logic [3:0] ev);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r = r; t.f = 1'b0;
    t.exp_ready = er; t.exp_valid = ev;
    return t;
  endfunction

  // Drive one cycle. Check the pre-edge outputs against the scoreboard, then update the model and clock.
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] r, input logic f, input bit verbose);
    logic       acc;
    logic [3:0] exp_v;
    in_valid = v; in_sel = s; in_data = d; out_ready = r; flush = f;
    #1;
    exp_v = '0;
    for (int k = 0; k < 4; k++) exp_v[k] = (sb[k].size() != 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, !f && (sb[s].size() < D)});
    chk("out_valid", {60'd0, out_valid}, {60'd0, exp_v});
    for (int k = 0; k < 4; k++) begin
      if (sb[k].size() != 0) chk($sformatf("head%0d", k), {48'd0, out_data[k*W +: W]}, {48'd0, sb[k][0]});
    end
    acc = v && !f && (sb[s].size() < D);
    for (int k = 0; k < 4; k++) begin
      if (!f && r[k] && sb[k].size() != 0) void'(sb[k].pop_front());
    end
    if (acc) sb[s].push_back(d);
    if (f) for (int k = 0; k < 4; k++) sb[k].delete();
    if (verbose)
      $display("txn v=%0b sel=%0d data=%h ready=%b flush=%0b accepted=%0b out_valid=%b",
               v, s, d, r, f, acc, out_valid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Routing, full and backpressure vectors.
    tbl[0]  = mk(1'b1, 2'd0, 16'hA000, 4'b0000, 1'b1, 4'b0000);
    tbl[1]  = mk(1'b1, 2'd1, 16'hA001, 4'b0000, 1'b1, 4'b0001);
    tbl[2]  = mk(1'b1, 2'd2, 16'hA002, 4'b0000, 1'b1, 4'b0011);
    tbl[3]  = mk(1'b1, 2'd3, 16'hA003, 4'b0000, 1'b1, 4'b0111);
    tbl[4]  = mk(1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b1111);
    tbl[5]  = mk(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000);
    tbl[6]  = mk(1'b1, 2'd2, 16'h1111, 4'b0000, 1'b1, 4'b0000);
    tbl[7]  = mk(1'b1, 2'd2, 16'h2222, 4'b0000, 1'b1, 4'b0100);
    tbl[8]  = mk(1'b1, 2'd2, 16'hDEAD, 4'b0000, 1'b0, 4'b0100);
    tbl[9]  = mk(1'b1, 2'd3, 16'h3333, 4'b0000, 1'b1, 4'b0100);
    tbl[10] = mk(1'b0, 2'd2, 16'h0000, 4'b0100, 1'b0, 4'b1100);
    tbl[11] = mk(1'b0, 2'd2, 16'h0000, 4'b0100, 1'b1, 4'b1100);
    tbl[12] = mk(1'b0, 2'd2, 16'h0000, 4'b1000, 1'b1, 4'b1000);
    tbl[13] = mk(1'b0, 2'd2, 16'h0000, 4'b0000, 1'b1, 4'b0000);
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].s; in_data = tbl[i].d;
      out_ready = tbl[i].r; flush = tbl[i].f;
      #1;
      chk($sformatf("tbl%0d_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_valid", i), {60'd0, out_valid}, {60'd0, tbl[i].exp_valid});
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, tbl[i].f, 1'b1);
    end

    // Reset asserted between edges clears the outputs without a clock edge.
    step(1'b1, 2'd0, 16'h5A5A, 4'b0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("pre_async_valid", {60'd0, out_valid}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {60'd0, out_valid}, 64'd0);
    chk("async_rst_data", out_data, 64'd0);
    for (int k = 0; k < 4; k++) sb[k].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A push and a pop on the same cycle keep the count and step through the wrap.
    step(1'b1, 2'd1, 16'h0BEE, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd1, 16'h0C00 + 16'(i), 4'b0010, 1'b0, 1'b1);
      chk("pp_valid", {60'd0, out_valid}, 64'd2);
      chk("pp_data", {48'd0, out_data[W +: W]}, {48'd0, 16'h0C00 + 16'(i)});
    end
    step(1'b0, 2'd0, 16'h0000, 4'b1111, 1'b0, 1'b1);

    // Flush takes priority over a push and a pop in the same cycle.
    step(1'b1, 2'd0, 16'h1234, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 2'd2, 16'h5678, 4'b0000, 1'b0, 1'b1);
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001; flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 2'd0, 16'h9999, 4'b0001, 1'b1, 1'b1);
    chk("flush_out_valid", {60'd0, out_valid}, 64'd0);
    step(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b1);

    // Random soak. The scoreboard checks in_ready, out_valid and order on every cycle.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(1)), 2'($urandom_range(3)), 16'($urandom),
           4'($urandom_range(15)), ($urandom_range(63) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
